// File: rtl/jt6295_adpcm_enc_if.sv
// rtl/jt6295_adpcm_enc_if.sv - PCM sample in / ADPCM code and packed byte out bundle
interface jt6295_adpcm_enc_if;
   logic [11:0] pcm_in;
   logic        pcm_valid;
   logic        pcm_ready;
   logic [3:0]  nib;
   logic        nib_valid;
   logic [7:0]  byte_out;
   logic        byte_valid;

   modport master (
      output pcm_in, pcm_valid,
      input  pcm_ready, nib, nib_valid, byte_out, byte_valid
   );

   modport slave (
      input  pcm_in, pcm_valid,
      output pcm_ready, nib, nib_valid, byte_out, byte_valid
   );
endinterface

// File: rtl/jt6295_adpcm_enc.sv
// rtl/jt6295_adpcm_enc.sv - OKI MSM6295 ADPCM encoder, one code per 5 cen cycles
// Successive approximation over three cen cycles keeps the reconstruction bit-exact with the decoder.
module jt6295_adpcm_enc (
   input  logic                clk,
   input  logic                rst,
   input  logic                cen,
   input  logic                clr,
   jt6295_adpcm_enc_if.slave   bus,
   output logic signed [11:0]  pred,
   output logic [5:0]          idx
);

   typedef enum logic [2:0] {S_IDLE, S_B2, S_B1, S_B0, S_UPD} state_t;

   localparam logic [10:0] STEP_TAB [0:48] = '{
      11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,   11'd31,
      11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,   11'd60,   11'd66,
      11'd73,   11'd80,   11'd88,   11'd97,   11'd107,  11'd118,  11'd130,  11'd143,
      11'd157,  11'd173,  11'd190,  11'd209,  11'd230,  11'd253,  11'd279,  11'd307,
      11'd337,  11'd371,  11'd408,  11'd449,  11'd494,  11'd544,  11'd598,  11'd658,
      11'd724,  11'd796,  11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411,
      11'd1552
   };

   state_t             state_q, state_d;
   logic signed [11:0] pred_q, pred_d;
   logic [5:0]         idx_q, idx_d;
   logic               sign_q, sign_d;
   logic [12:0]        mag_q, mag_d;
   logic [10:0]        d_q, d_d;
   logic [11:0]        q_q, q_d;
   logic [2:0]         code_q, code_d;
   logic               half_q, half_d;
   logic [3:0]         nib_q, nib_d;
   logic               nib_valid_q, nib_valid_d;
   logic [7:0]         byte_q, byte_d;
   logic               byte_valid_q, byte_valid_d;

   logic [10:0]        step;
   logic signed [12:0] diff;
   logic               bit_set;
   logic signed [12:0] sum;
   logic [5:0]         inc;
   logic [5:0]         t;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pred_q       <= '0;
         idx_q        <= '0;
         sign_q       <= 1'b0;
         mag_q        <= '0;
         d_q          <= '0;
         q_q          <= '0;
         code_q       <= '0;
         half_q       <= 1'b0;
         nib_q        <= '0;
         nib_valid_q  <= 1'b0;
         byte_q       <= '0;
         byte_valid_q <= 1'b0;
      end else if (cen) begin
         state_q      <= state_d;
         pred_q       <= pred_d;
         idx_q        <= idx_d;
         sign_q       <= sign_d;
         mag_q        <= mag_d;
         d_q          <= d_d;
         q_q          <= q_d;
         code_q       <= code_d;
         half_q       <= half_d;
         nib_q        <= nib_d;
         nib_valid_q  <= nib_valid_d;
         byte_q       <= byte_d;
         byte_valid_q <= byte_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (bus.pcm_valid) state_d = S_B2;
            S_B2:    state_d = S_B1;
            S_B1:    state_d = S_B0;
            S_B0:    state_d = S_UPD;
            S_UPD:   state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      step    = STEP_TAB[idx_q];
      diff    = $signed({bus.pcm_in[11], bus.pcm_in}) - $signed({pred_q[11], pred_q});
      bit_set = (mag_q >= {2'b00, d_q});
      sum     = sign_q ? ($signed({pred_q[11], pred_q}) - $signed({1'b0, q_q}))
                       : ($signed({pred_q[11], pred_q}) + $signed({1'b0, q_q}));
      inc     = {3'b000, code_q[1:0], 1'b0} + 6'd2;
      t       = code_q[2] ? (idx_q + inc) : (idx_q - 6'd1);

      pred_d       = pred_q;
      idx_d        = idx_q;
      sign_d       = sign_q;
      mag_d        = mag_q;
      d_d          = d_q;
      q_d          = q_q;
      code_d       = code_q;
      half_d       = half_q;
      nib_d        = nib_q;
      byte_d       = byte_q;
      nib_valid_d  = 1'b0;
      byte_valid_d = 1'b0;

      if (clr) begin
         pred_d = '0;
         idx_d  = '0;
         half_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.pcm_valid) begin
                  sign_d = diff[12];
                  mag_d  = diff[12] ? 13'(-diff) : 13'(diff);
                  d_d    = step;
                  q_d    = {1'b0, step >> 3};
                  code_d = '0;
               end
            end
            S_B2, S_B1, S_B0: begin
               // code bits shift in MSB first, so b2 ends up in code_q[2]
               code_d = {code_q[1:0], bit_set};
               if (bit_set) begin
                  mag_d = mag_q - {2'b00, d_q};
                  q_d   = q_q + {1'b0, d_q};
               end
               d_d = d_q >> 1;
            end
            S_UPD: begin
               if (sum > 13'sd2047)
                  pred_d = 12'h7FF;
               else if (sum < -13'sd2048)
                  pred_d = 12'h800;
               else
                  pred_d = sum[11:0];
               idx_d       = (t > 6'd48) ? (code_q[2] ? 6'd48 : 6'd0) : t;
               nib_d       = {sign_q, code_q};
               nib_valid_d = 1'b1;
               if (!half_q) begin
                  byte_d = {sign_q, code_q, 4'h0};
                  half_d = 1'b1;
               end else begin
                  byte_d       = {byte_q[7:4], sign_q, code_q};
                  byte_valid_d = 1'b1;
                  half_d       = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.pcm_ready  = (state_q == S_IDLE);
      bus.nib        = nib_q;
      bus.nib_valid  = nib_valid_q;
      bus.byte_out   = byte_q;
      bus.byte_valid = byte_valid_q;
      pred           = pred_q;
      idx            = idx_q;
   end

endmodule

// File: tb/tb_jt6295_adpcm_enc.sv
// tb/tb_jt6295_adpcm_enc.sv - random and directed bench against an OKI encode/decode model
module tb_jt6295_adpcm_enc;

   logic clk = 1'b0;
   logic rst, cen, clr;
   logic signed [11:0] dut_pred;
   logic [5:0]         dut_idx;

   jt6295_adpcm_enc_if bus ();

   jt6295_adpcm_enc dut (
      .clk  (clk),
      .rst  (rst),
      .cen  (cen),
      .clr  (clr),
      .bus  (bus.slave),
      .pred (dut_pred),
      .idx  (dut_idx)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int steps [49] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66,
                      73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253,
                      279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876,
                      963, 1060, 1166, 1282, 1411, 1552};
   int idx_adj [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

   int m_pred, m_idx, m_half, m_first;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   function automatic int enc_nib(input int pcm);
      int diff, mag, d, code;
      diff = pcm - m_pred;
      mag  = (diff < 0) ? -diff : diff;
      d    = steps[m_idx];
      code = 0;
      for (int k = 2; k >= 0; k--) begin
         if (mag >= d) begin
            code += (1 << k);
            mag  -= d;
         end
         d = d / 2;
      end
      return ((diff < 0) ? 8 : 0) + code;
   endfunction

   function automatic void dec_nib(input int n);
      int st, q;
      st = steps[m_idx];
      q  = st / 8;
      if ((n & 4) != 0) q += st;
      if ((n & 2) != 0) q += st / 2;
      if ((n & 1) != 0) q += st / 4;
      m_pred = ((n & 8) != 0) ? m_pred - q : m_pred + q;
      if (m_pred > 2047)  m_pred = 2047;
      if (m_pred < -2048) m_pred = -2048;
      m_idx += idx_adj[n & 7];
      if (m_idx > 48) m_idx = 48;
      if (m_idx < 0)  m_idx = 0;
   endfunction

   function automatic void model_clear();
      m_pred  = 0;
      m_idx   = 0;
      m_half  = 0;
      m_first = 0;
   endfunction

   task automatic step_cycle(input bit c);
      cen = c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cen = 1'b0;
      clr = 1'b0;
      bus.pcm_valid = 1'b0;
      bus.pcm_in = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
   endtask

   task automatic send(input int pcm, input bit gaps, output int got_nib);
      int w, n, budget, exp_n, exp_byte;
      bit early, exp_bv;
      w = 0;
      while (!bus.pcm_ready && w < 20) begin
         step_cycle(1'b1);
         w++;
      end
      if (!bus.pcm_ready) check("ready_timeout", 32'd0, 32'd1);
      exp_n = enc_nib(pcm);
      bus.pcm_in    = pcm[11:0];
      bus.pcm_valid = 1'b1;
      step_cycle(1'b1);
      check("accepted", 32'(bus.pcm_ready), 32'd0);
      bus.pcm_valid = 1'b0;
      n = 0;
      budget = 0;
      early = 1'b0;
      while (n < 4 && budget < 60) begin
         bit c;
         c = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (gaps) begin
            bus.pcm_valid = 1'($urandom_range(0, 1));
            bus.pcm_in    = 12'($urandom);
         end
         step_cycle(c);
         if (c) n++;
         if (n < 4 && bus.nib_valid) early = 1'b1;
         budget++;
      end
      bus.pcm_valid = 1'b0;
      check("early_nib_valid", 32'(early), 32'd0);
      check("latency_edges", n, 4);
      check("nib_valid", 32'(bus.nib_valid), 32'd1);
      check("nib", 32'(bus.nib), exp_n);
      dec_nib(exp_n);
      check("pred", dut_pred, m_pred);
      check("idx", 32'(dut_idx), m_idx);
      if (m_half == 0) begin
         m_first = exp_n;
         m_half  = 1;
         exp_bv  = 1'b0;
         exp_byte = 0;
      end else begin
         exp_byte = m_first * 16 + exp_n;
         m_half   = 0;
         exp_bv   = 1'b1;
      end
      check("byte_valid", 32'(bus.byte_valid), 32'(exp_bv));
      if (exp_bv) check("byte_out", 32'(bus.byte_out), exp_byte);
      if (gaps && $urandom_range(0, 3) == 0) begin
         step_cycle(1'b0);
         check("hold_nib_valid", 32'(bus.nib_valid), 32'd1);
         check("hold_nib", 32'(bus.nib), exp_n);
      end
      got_nib = exp_n;
      got_nib = int'(bus.nib);
   endtask

   initial begin
      int nb, max_idx, p;
      bit seen, bad_bound;

      do_reset();
      check("rst_ready", 32'(bus.pcm_ready), 32'd1);
      check("rst_nib_valid", 32'(bus.nib_valid), 32'd0);
      check("rst_byte_valid", 32'(bus.byte_valid), 32'd0);
      check("rst_nib", 32'(bus.nib), 32'd0);
      check("rst_byte_out", 32'(bus.byte_out), 32'd0);
      check("rst_pred", dut_pred, 32'd0);
      check("rst_idx", 32'(dut_idx), 32'd0);

      send(100, 1'b0, nb);
      check("p100_nib", nb, 7);
      check("p100_pred", dut_pred, 30);
      check("p100_idx", 32'(dut_idx), 8);
      send(30, 1'b0, nb);
      check("p30_nib", nb, 0);
      check("p30_pred", dut_pred, 34);
      check("p30_idx", 32'(dut_idx), 7);
      check("p30_byte", 32'(bus.byte_out), 32'h70);
      check("p30_byte_valid", 32'(bus.byte_valid), 32'd1);

      do_reset();
      send(-100, 1'b0, nb);
      check("m100_nib", nb, 15);
      check("m100_pred", dut_pred, -30);
      check("m100_idx", 32'(dut_idx), 8);
      do_reset();
      send(0, 1'b0, nb);
      check("zero_nib", nb, 0);
      check("zero_pred", dut_pred, 2);
      check("zero_idx", 32'(dut_idx), 0);

      do_reset();
      bad_bound = 1'b0;
      for (int i = 0; i < 30; i++) begin
         send(2047, 1'b0, nb);
         if (dut_idx > 6'd48 || dut_pred > 12'sd2047 || nb[3]) bad_bound = 1'b1;
      end
      check("pos_full_bounds", 32'(bad_bound), 32'd0);

      do_reset();
      max_idx = 0;
      bad_bound = 1'b0;
      for (int i = 0; i < 30; i++) begin
         send((i % 2 == 0) ? 2047 : -2048, 1'b1, nb);
         if (int'(dut_idx) > max_idx) max_idx = int'(dut_idx);
         if (dut_idx > 6'd48) bad_bound = 1'b1;
      end
      check("alt_idx_bound", 32'(bad_bound), 32'd0);
      check("alt_idx_max", max_idx, 48);
      check("alt_idx_final", 32'(dut_idx), 48);

      do_reset();
      send(500, 1'b0, nb);
      bus.pcm_in    = 12'd123;
      bus.pcm_valid = 1'b1;
      step_cycle(1'b1);
      bus.pcm_valid = 1'b0;
      step_cycle(1'b1);
      clr           = 1'b1;
      bus.pcm_valid = 1'b1;
      bus.pcm_in    = 12'd777;
      step_cycle(1'b1);
      clr           = 1'b0;
      bus.pcm_valid = 1'b0;
      model_clear();
      check("clr_ready", 32'(bus.pcm_ready), 32'd1);
      check("clr_nib_valid", 32'(bus.nib_valid), 32'd0);
      check("clr_byte_valid", 32'(bus.byte_valid), 32'd0);
      check("clr_pred", dut_pred, 32'd0);
      check("clr_idx", 32'(dut_idx), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step_cycle(1'b1);
         if (bus.nib_valid) seen = 1'b1;
      end
      check("clr_no_nib", 32'(seen), 32'd0);
      send(-300, 1'b0, nb);
      send(250, 1'b0, nb);

      do_reset();
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            p = int'($urandom_range(0, 4095)) - 2048;
         end else begin
            p = m_pred + int'($urandom_range(0, 400)) - 200;
            if (p > 2047)  p = 2047;
            if (p < -2048) p = -2048;
         end
         send(p, 1'b1, nb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jt6295_adpcm_enc.md
JT6295_ADPCM_ENC -- requirements
Module: jt6295_adpcm_enc

Interface
REQ-001 rst  input  1  asynchronous active-high reset.
REQ-002 clk  input  1  single clock.
REQ-003 cen  input  1  clock enable; all state changes only on clk edges with cen=1.
REQ-004 clr  input  1  synchronous encoder restart; effective only when cen=1.
REQ-005 pcm_in  input  12  signed PCM sample, two's complement.
REQ-006 pcm_valid  input  1  pcm_in is valid.
REQ-007 pcm_ready  output  1  encoder accepts a sample; high only in IDLE.
REQ-008 nib  output  4  OKI ADPCM code: bit3 sign, bits2:0 magnitude.
REQ-009 nib_valid  output  1  nib is new; high for exactly one cen period per sample.
REQ-010 byte_out  output  8  packed pair of codes, first code in bits 7:4.
REQ-011 byte_valid  output  1  byte_out complete; high for one cen period on every second code.

Function
REQ-012 State is predictor pred (signed 12) and step index idx (0..48); step table is the 49-entry OKI table, 16,17,19,21,...,1411,1552, shared with the decoder.
REQ-013 FSM states are IDLE, B2, B1, B0 and UPD, visited in that order.
REQ-014 IDLE -> B2 on a cen edge with pcm_valid=1; the encoder captures diff = pcm_in - pred (signed 13), sign = diff<0, mag = |diff|, d = step[idx], q = step[idx]>>3.
REQ-015 B2, B1 and B0 each take one cen cycle: if mag >= d, set the bit, mag -= d, q += d; in all cases d >>= 1.
REQ-016 UPD: pred = clamp(sign ? pred-q : pred+q, -2048, 2047); 13-bit intermediate; no wrap.
REQ-017 UPD index update:
- Compute t = b2 ? idx + {2,4,6,8}[b1:b0] : idx - 1, in 6-bit arithmetic.
- If t > 48, idx = b2 ? 48 : 0; otherwise idx = t.
REQ-018 UPD writes nib = {sign,b2,b1,b0}, asserts nib_valid, returns to IDLE.
REQ-019 Latency: a sample accepted on cen edge N yields nib_valid=1 from cen edge N+4 until edge N+5.
REQ-020 Throughput is one sample per 5 cen cycles; pcm_valid outside IDLE is ignored, with no buffering.
REQ-021 Packing uses a half flag.
- First code: held in byte_out[7:4], byte_valid=0.
- Second code: byte_out = {first, second}, byte_valid asserted together with nib_valid, half cleared.
REQ-022 The reconstruction (pred, idx) after every code equals the decoder fed the same code stream from reset, bit-exact.
REQ-023 cen=0 freezes all state and outputs; nib_valid and byte_valid stay at their current value.
REQ-024 clr=1 with cen=1 has priority over every other transition.
- Sets pred=0, idx=0, half=0, FSM=IDLE, nib_valid=0, byte_valid=0.
- Discards any in-flight sample.
- A sample offered in the same cycle is not accepted.

Reset
REQ-025 rst=1 forces pred=0, idx=0, half=0, FSM=IDLE, nib=0, nib_valid=0, byte_out=0, byte_valid=0, so pcm_ready=1.
REQ-026 Deasserting rst needs no cen; the first cen edge after release may accept a sample.

Verification
REQ-027 Reset then pcm_in=+100 -> nib=0x7, pred=30, idx=8, nib_valid at 4th cen edge after acceptance.
REQ-028 After REQ-027 sample, pcm_in=30 -> diff 0, nib=0x0, pred=34, idx=7; byte_out=0x70 with byte_valid=1.
REQ-029 Reset then pcm_in=-100 -> nib=0xF, pred=-30, idx=8; reset then pcm_in=0 -> nib=0x0, pred=2, idx stays 0 (underflow clamp).
REQ-030 Drive 30 samples of +2047 -> idx never >48 and reaches 48; pred never >2047; no sign flip.
REQ-031 Assert clr during B1 -> no nib_valid, pred=0, idx=0, half=0, pcm_ready=1 next cen.
REQ-032 Run 10k random samples with random cen gaps -> each nib fed to the jt6295 decoder model reproduces pred and idx exactly.
